// File: rtl/alu_arbiter.sv
// Purpose: two-requester arbiter feeding a single-entry registered 32-bit ALU result slot.
// Latency: 1 cycle from acceptance to resp_valid; one operation per cycle when drained.
// Backpressure: resp_ready=0 while FULL stalls both requesters (readys low, result held).
module alu_arbiter #(
   parameter int RR_EN = 1,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [31:0]      req0_a,
   input  logic [31:0]      req0_b,
   input  logic [3:0]       req0_sel,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [31:0]      req1_a,
   input  logic [31:0]      req1_b,
   input  logic [3:0]       req1_sel,
   output logic             resp_valid,
   input  logic             resp_ready,
   output logic [31:0]      resp_data,
   output logic             resp_id,
   output logic             busy,
   output logic [CNT_W-1:0] op_count
);

   typedef enum logic {ST_EMPTY = 1'b0, ST_FULL = 1'b1} state_t;

   state_t            r_state;
   state_t            w_state_nxt;
   logic [31:0]       r_resp_data;
   logic              r_resp_id;
   logic              r_last;
   logic [CNT_W-1:0]  r_op_count;

   logic              w_can_accept;
   logic              w_gnt0;
   logic              w_gnt1;
   logic              w_acc0;
   logic              w_acc1;
   logic              w_accept;
   logic              w_drain;
   logic [31:0]       w_a;
   logic [31:0]       w_b;
   logic [3:0]        w_sel;
   logic [4:0]        w_sh;
   logic signed [31:0] w_sra;
   logic [31:0]       w_alu;

   // The slot can take a new operation when empty, or when its current result leaves this cycle.
   assign w_can_accept = (r_state == ST_EMPTY) || resp_ready;

   // Requester 0 wins when alone, under fixed priority, or when requester 1 was granted last.
   assign w_gnt0 = req0_valid & (~req1_valid | (RR_EN == 0) | r_last);
   assign w_gnt1 = req1_valid & ~w_gnt0;

   assign req0_ready = w_gnt0 & w_can_accept;
   assign req1_ready = w_gnt1 & w_can_accept;
   assign w_acc0     = req0_valid & req0_ready;
   assign w_acc1     = req1_valid & req1_ready;
   assign w_accept   = w_acc0 | w_acc1;
   assign w_drain    = resp_valid & resp_ready;

   // Operands come from whichever requester holds the grant.
   assign w_a   = w_gnt1 ? req1_a   : req0_a;
   assign w_b   = w_gnt1 ? req1_b   : req0_b;
   assign w_sel = w_gnt1 ? req1_sel : req0_sel;
   assign w_sh  = w_b[4:0];
   // Kept in its own signed net so the ternary below cannot turn it into a logical shift.
   assign w_sra = $signed(w_a) >>> w_sh;

   // ALU: funct3 selects the operation, bit 30 picks SUB/SRA variants.
   always_comb begin
      w_alu = 32'd0;
      case (w_sel[2:0])
         3'b000:  w_alu = w_sel[3] ? (w_a - w_b) : (w_a + w_b);
         3'b001:  w_alu = w_a << w_sh;
         3'b010:  w_alu = {31'd0, ($signed(w_a) < $signed(w_b))};
         3'b011:  w_alu = {31'd0, (w_a < w_b)};
         3'b100:  w_alu = w_a ^ w_b;
         3'b101:  w_alu = w_sel[3] ? w_sra : (w_a >> w_sh);
         3'b110:  w_alu = w_a | w_b;
         default: w_alu = w_a & w_b;
      endcase
   end

   // Next state: a new acceptance always fills; a drain without refill empties.
   always_comb begin
      w_state_nxt = r_state;
      if (w_accept) begin
         w_state_nxt = ST_FULL;
      end else if ((r_state == ST_FULL) && resp_ready) begin
         w_state_nxt = ST_EMPTY;
      end
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_EMPTY;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Result slot, owner id and round-robin pointer load only on acceptance.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_resp_data <= 32'd0;
         r_resp_id   <= 1'b0;
         r_last      <= 1'b1;
      end else if (w_accept) begin
         r_resp_data <= w_alu;
         r_resp_id   <= w_acc1;
         r_last      <= w_acc1;
      end
   end

   // Completed-response counter, wraps naturally.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_op_count <= '0;
      end else if (w_drain) begin
         r_op_count <= r_op_count + {{(CNT_W-1){1'b0}}, 1'b1};
      end
   end

   assign resp_valid = (r_state == ST_FULL);
   assign resp_data  = r_resp_data;
   assign resp_id    = r_resp_id;
   assign op_count   = r_op_count;
   assign busy       = resp_valid | req0_valid | req1_valid;

endmodule

// File: tb/tb_alu_arbiter.sv
module tb_alu_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req0_valid, req0_ready, req1_valid, req1_ready;
   logic [31:0] req0_a, req0_b, req1_a, req1_b;
   logic [3:0]  req0_sel, req1_sel;
   logic        resp_valid, resp_ready, resp_id, busy;
   logic [31:0] resp_data;
   logic [15:0] op_count;

   logic        fp_req0_valid, fp_req0_ready, fp_req1_valid, fp_req1_ready;
   logic [31:0] fp_a, fp_b;
   logic [3:0]  fp_sel;
   logic        fp_resp_valid, fp_resp_ready, fp_resp_id, fp_busy;
   logic [31:0] fp_resp_data;
   logic [1:0]  fp_op_count;

   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   logic [32:0] sb_q[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   alu_arbiter #(.RR_EN(1), .CNT_W(16)) u_dut (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_sel(req0_sel),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_sel(req1_sel),
      .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data), .resp_id(resp_id),
      .busy(busy), .op_count(op_count)
   );

   alu_arbiter #(.RR_EN(0), .CNT_W(2)) u_fp (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(fp_req0_valid), .req0_ready(fp_req0_ready), .req0_a(fp_a), .req0_b(fp_b), .req0_sel(fp_sel),
      .req1_valid(fp_req1_valid), .req1_ready(fp_req1_ready), .req1_a(fp_a), .req1_b(fp_b), .req1_sel(fp_sel),
      .resp_valid(fp_resp_valid), .resp_ready(fp_resp_ready), .resp_data(fp_resp_data), .resp_id(fp_resp_id),
      .busy(fp_busy), .op_count(fp_op_count)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // Present one operation and hold it until accepted; returns the acceptance cycle.
   task automatic drive(input bit id, input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] sel, output int acc);
      bit done = 1'b0;
      acc = -1;
      if (id == 1'b0) begin
         req0_a = a; req0_b = b; req0_sel = sel; req0_valid = 1'b1;
      end else begin
         req1_a = a; req1_b = b; req1_sel = sel; req1_valid = 1'b1;
      end
      for (int i = 0; i < 20 && !done; i++) begin
         @(negedge clk);
         if ((id == 1'b0 && req0_ready) || (id == 1'b1 && req1_ready)) begin
            acc  = cyc;
            done = 1'b1;
         end
      end
      if (!done) begin
         checks++;
         errors++;
         $display("FAIL drive_timeout actual=no_ready required=ready id=%0d", id);
      end else begin
         @(posedge clk);
      end
      #1;
      if (id == 1'b0) req0_valid = 1'b0;
      else            req1_valid = 1'b0;
   endtask

   // Scoreboard monitor: every response handshake must match the oldest expected entry.
   always @(negedge clk) begin : mon
      logic [32:0] e;
      checks++;
      if (req0_ready && req1_ready) begin
         errors++;
         $display("FAIL both_ready actual=11 required=at_most_one");
      end
      if (rst_n && resp_valid && resp_ready) begin
         if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_unexpected actual id=%0d data=%h required=none", resp_id, resp_data);
         end else begin
            e = sb_q.pop_front();
            chk("sb_id", {31'd0, resp_id}, {31'd0, e[32]});
            chk("sb_data", resp_data, e[31:0]);
         end
      end
   end

   initial begin
      #50000;
      $display("FAIL global_timeout actual=running required=finished");
      $fatal(1, "timeout");
   end

   initial begin
      int c0, c1;
      logic [31:0] ta [4];
      logic [31:0] tb_ [4];
      logic [3:0]  ts [4];
      logic [31:0] tr [4];

      rst_n = 1'b0;
      req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_sel = '0;
      req1_valid = 1'b1; req1_a = '0; req1_b = '0; req1_sel = '0;
      resp_ready = 1'b1;
      fp_req0_valid = 1'b0; fp_req1_valid = 1'b0;
      fp_a = 32'd1; fp_b = 32'd1; fp_sel = 4'b0000; fp_resp_ready = 1'b1;

      // Reset state; readys follow the EMPTY state while reset is held.
      #12;
      chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
      chk("rst_resp_data", resp_data, 32'd0);
      chk("rst_resp_id", {31'd0, resp_id}, 32'd0);
      chk("rst_op_count", {16'd0, op_count}, 32'd0);
      chk("rst_req1_ready", {31'd0, req1_ready}, 32'd1);
      chk("rst_busy_req", {31'd0, busy}, 32'd1);
      req1_valid = 1'b0;
      #1;
      chk("rst_busy_idle", {31'd0, busy}, 32'd0);
      @(posedge clk); #1 rst_n = 1'b1;

      // ADD 5+7 from requester 0, one-cycle latency, count 1.
      sb_q.push_back({1'b0, 32'd12});
      drive(1'b0, 32'd5, 32'd7, 4'b0000, c0);
      @(negedge clk);
      chk("add_latency_valid", {31'd0, resp_valid}, 32'd1);
      @(posedge clk); #1;
      chk("add_op_count", {16'd0, op_count}, 32'd1);

      // SLT signed from requester 1 (leaves requester 1 as last granted).
      sb_q.push_back({1'b1, 32'd1});
      drive(1'b1, 32'hFFFF_FFFF, 32'd1, 4'b0010, c1);

      // Tie under round robin: requester 0 first, requester 1 on the next cycle.
      sb_q.push_back({1'b0, 32'hFFFF_FFFE});
      sb_q.push_back({1'b1, 32'hF800_0000});
      fork
         drive(1'b0, 32'd3, 32'd5, 4'b1000, c0);
         drive(1'b1, 32'h8000_0000, 32'd4, 4'b1101, c1);
      join
      chk("rr_consecutive", c1 - c0, 32'd1);

      // SLTU with the same operands, SLL with shift amount 33 (uses 1).
      sb_q.push_back({1'b0, 32'd0});
      drive(1'b0, 32'hFFFF_FFFF, 32'd1, 4'b0011, c0);
      sb_q.push_back({1'b1, 32'd2});
      drive(1'b1, 32'd1, 32'd33, 4'b0001, c1);

      // Further datapath vectors.
      ta[0] = 32'h8000_0000; tb_[0] = 32'd31;        ts[0] = 4'b0101; tr[0] = 32'd1;
      ta[1] = 32'hFF00_FF00; tb_[1] = 32'h0FF0_0FF0; ts[1] = 4'b0111; tr[1] = 32'h0F00_0F00;
      ta[2] = 32'hFFFF_FFFF; tb_[2] = 32'd2;         ts[2] = 4'b0000; tr[2] = 32'd1;
      ta[3] = 32'h4000_0000; tb_[3] = 32'd4;         ts[3] = 4'b1101; tr[3] = 32'h0400_0000;
      for (int i = 0; i < 4; i++) begin
         sb_q.push_back({1'b0, tr[i]});
         drive(1'b0, ta[i], tb_[i], ts[i], c0);
      end
      @(posedge clk); @(posedge clk); #1;
      chk("count_after_vectors", {16'd0, op_count}, 32'd10);

      // Backpressure: result held, requester 1 stalled, release drains and accepts together.
      resp_ready = 1'b0;
      sb_q.push_back({1'b0, 32'hFF00_00FF});
      drive(1'b0, 32'hF0F0_0000, 32'h0FF0_00FF, 4'b0100, c0);
      req1_a = 32'h0000_1200; req1_b = 32'h0000_0034; req1_sel = 4'b0110; req1_valid = 1'b1;
      sb_q.push_back({1'b1, 32'h0000_1234});
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("bp_req1_ready", {31'd0, req1_ready}, 32'd0);
         chk("bp_resp_data", resp_data, 32'hFF00_00FF);
         chk("bp_resp_valid", {31'd0, resp_valid}, 32'd1);
      end
      chk("bp_busy", {31'd0, busy}, 32'd1);
      @(posedge clk); #1 resp_ready = 1'b1;
      @(negedge clk);
      chk("bp_release_ready", {31'd0, req1_ready}, 32'd1);
      @(posedge clk); #1 req1_valid = 1'b0;
      @(posedge clk); #1;
      chk("bp_op_count", {16'd0, op_count}, 32'd12);

      // Reset while FULL: result discarded asynchronously, not counted.
      resp_ready = 1'b0;
      sb_q.push_back({1'b0, 32'd2});
      drive(1'b0, 32'd1, 32'd1, 4'b0000, c0);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_resp_valid", {31'd0, resp_valid}, 32'd0);
      chk("arst_op_count", {16'd0, op_count}, 32'd0);
      chk("arst_resp_data", resp_data, 32'd0);
      sb_q.delete();
      resp_ready = 1'b1;
      @(posedge clk); #1 rst_n = 1'b1;

      // First tie after reset goes to requester 0.
      sb_q.push_back({1'b0, 32'd13});
      sb_q.push_back({1'b1, 32'd7});
      fork
         drive(1'b0, 32'd10, 32'd3, 4'b0000, c0);
         drive(1'b1, 32'd10, 32'd3, 4'b1000, c1);
      join
      chk("arst_first_tie", c1 - c0, 32'd1);
      @(posedge clk); @(posedge clk); #1;
      chk("arst_op_count_after", {16'd0, op_count}, 32'd2);
      chk("sb_drained", sb_q.size(), 32'd0);

      // Fixed priority: requester 0 granted every cycle; 2-bit counter wraps 6 -> 2.
      @(posedge clk); #1 fp_req0_valid = 1'b1; fp_req1_valid = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         chk("fp_req0_ready", {31'd0, fp_req0_ready}, 32'd1);
         chk("fp_req1_ready", {31'd0, fp_req1_ready}, 32'd0);
         if (i > 0) begin
            chk("fp_resp_id", {31'd0, fp_resp_id}, 32'd0);
            chk("fp_resp_data", fp_resp_data, 32'd2);
         end
      end
      @(posedge clk); #1 fp_req0_valid = 1'b0; fp_req1_valid = 1'b0;
      @(posedge clk); #1;
      chk("fp_op_count_wrap", {30'd0, fp_op_count}, 32'd2);
      chk("fp_resp_valid_idle", {31'd0, fp_resp_valid}, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 The block SHALL have parameter RR_EN, default 1, selecting round-robin arbitration (1) or fixed priority with requester 0 winning (0).
REQ-002 The block SHALL have parameter CNT_W, default 16, setting the width of the completed-operation counter.
REQ-003 clk  input  1  Single clock; all state SHALL update on the rising edge.
REQ-004 rst_n  input  1  Reset, asynchronous and active-low.
REQ-005 req0_valid  input  1  Requester 0 has an operation pending.
REQ-006 req0_ready  output  1  Requester 0 operation is accepted this cycle.
REQ-007 req0_a, req0_b  input  32 each  Requester 0 operands.
REQ-008 req0_sel  input  4  Requester 0 operation: [2:0]=funct3, [3]=instruction bit 30.
REQ-009 req1_valid, req1_ready, req1_a, req1_b, req1_sel SHALL have the same directions, widths and meanings for requester 1.
REQ-010 resp_valid  output  1  A result is held on resp_data.
REQ-011 resp_ready  input  1  The consumer takes the result this cycle.
REQ-012 resp_data  output  32  ALU result.
REQ-013 resp_id  output  1  Index of the requester that owns resp_data.
REQ-014 busy  output  1  Asserted whenever resp_valid is high or any reqN_valid is high.
REQ-015 op_count  output  CNT_W  Count of completed response handshakes.

Function
REQ-016 The datapath SHALL be the core 32-bit ALU operation set, keyed by sel[2:0]:
- 000: ADD when sel[3]=0, SUB when sel[3]=1.
- 001: SLL.
- 010: SLT, signed.
- 011: SLTU, unsigned.
- 100: XOR.
- 101: SRL when sel[3]=0, SRA when sel[3]=1.
- 110: OR.
- 111: AND.
REQ-017 All shifts SHALL use b[4:0] as the amount, and all arithmetic SHALL wrap modulo 2^32.
REQ-018 The block SHALL have two states: EMPTY (resp_valid=0) and FULL (resp_valid=1).
REQ-019 can_accept SHALL be 1 when the state is EMPTY, or when the state is FULL and resp_ready=1 (pass-through, one operation per cycle).
REQ-020 The grant SHALL be combinational:
- Only one valid: that requester wins.
- Both valid with RR_EN=1: the requester not granted last wins.
- Both valid with RR_EN=0: requester 0 wins.
REQ-021 reqN_ready SHALL equal grantN AND can_accept, and at most one ready SHALL be high in a cycle.
REQ-022 Acceptance SHALL occur when reqN_valid and reqN_ready are both 1.
- On that edge, resp_data SHALL be loaded with the ALU result, resp_id with N, and resp_valid with 1.
- Latency SHALL be exactly 1 cycle from acceptance to resp_valid.
REQ-023 FULL with resp_ready=1 and no acceptance SHALL go to EMPTY, with resp_data and resp_id holding their last values.
REQ-024 FULL with resp_ready=0 SHALL hold resp_valid, resp_data and resp_id stable, and both readys SHALL be 0.
REQ-025 The last-granted pointer SHALL update only on an acceptance; a grant that is not accepted SHALL NOT rotate priority.
REQ-026 op_count SHALL increment by 1 on each resp_valid AND resp_ready cycle and SHALL wrap from all-ones to 0.
REQ-027 Requesters SHALL hold valid and operands stable until they are accepted, and valid SHALL NOT depend on ready; the block SHALL NOT depend on any behaviour outside this rule.
REQ-028 Simultaneous response drain and new acceptance SHALL leave resp_valid=1 with the new result and SHALL count the drained response.

Reset
REQ-029 Asserting rst_n low SHALL immediately set:
- resp_valid=0, resp_data=0, resp_id=0, op_count=0;
- state to EMPTY;
- last-granted pointer to 1, so requester 0 wins first.
REQ-030 A result held at reset SHALL be discarded and not counted.
REQ-031 The readys SHALL be combinational and SHALL follow the EMPTY state while rst_n is low.
REQ-032 The first acceptance after reset SHALL occur no earlier than the first rising edge after rst_n deasserts.

Verification
REQ-033 The bench SHALL cover req0 ADD: a=5, b=7, sel=0000, resp_ready=1 -> next cycle resp_valid=1, resp_data=12, resp_id=0, op_count=1.
REQ-034 The bench SHALL cover both requesters valid with RR_EN=1:
- req0 SUB, 3-5, sel=1000;
- req1 SRA, 0x80000000>>4, sel=1101;
- -> responses 0xFFFFFFFE (id 0), then 0xF8000000 (id 1), on consecutive cycles.
REQ-035 The bench SHALL cover backpressure: resp_ready=0 for 3 cycles with req1 valid -> req1_ready=0 and resp_data stable; on release, response and acceptance occur in the same cycle.
REQ-036 The bench SHALL cover the signed/unsigned compares: SLT a=0xFFFFFFFF, b=1 -> 1; SLTU with the same operands -> 0; shift amount b=33 on SLL of 1 -> 2.
REQ-037 The bench SHALL cover fixed priority: RR_EN=0 with both requesters valid continuously -> req0 granted every cycle and req1 never granted.
REQ-038 The bench SHALL cover reset while FULL: rst_n low mid-cycle -> resp_valid=0 and op_count=0 asynchronously; after release, req0 wins the first tie.
